// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register indices and
// the default datapath width used by the PIPE decode/write-back slice.
package y86_pkg;

    localparam int WORD_W_DEF = 64;

    // Register index meaning "no register"
    localparam int RNONE = 15;
    // Stack pointer register index
    localparam int RSP   = 4;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

endpackage

// File: rtl/regfile_2r2w.sv
// Architectural register file: two combinational read ports that see the
// write-back values of the current cycle, and two write ports where the
// M port overrides the E port on an index collision.
module regfile_2r2w #(
    parameter int WORD_W = 64,
    parameter int RIDX_W = 4,
    parameter int NREGS  = 15,
    parameter int RNONE  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] ra_a,
    input  logic [RIDX_W-1:0] ra_b,
    output logic [WORD_W-1:0] rd_a,
    output logic [WORD_W-1:0] rd_b,
    input  logic [RIDX_W-1:0] wa_e,
    input  logic [WORD_W-1:0] wd_e,
    input  logic [RIDX_W-1:0] wa_m,
    input  logic [WORD_W-1:0] wd_m
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WORD_W-1:0] regs [NREGS];

    // An index addresses a real register only if it is not the "none"
    // marker and lies inside the implemented array.
    function automatic logic idx_ok(input logic [RIDX_W-1:0] idx);
        return (idx != RIDX_W'(RNONE)) && ({1'b0, idx} < (RIDX_W + 1)'(NREGS));
    endfunction

    // Read with same-cycle forwarding; M beats E, invalid indices read 0.
    function automatic logic [WORD_W-1:0] read_fwd(
        input logic [RIDX_W-1:0] s,
        input logic [WORD_W-1:0] stored,
        input logic [RIDX_W-1:0] we_idx,
        input logic [WORD_W-1:0] we_val,
        input logic [RIDX_W-1:0] wm_idx,
        input logic [WORD_W-1:0] wm_val
    );
        if (!idx_ok(s))
            return '0;
        else if (s == wm_idx)
            return wm_val;
        else if (s == we_idx)
            return we_val;
        else
            return stored;
    endfunction

    // Decode read ports with write-back bypass
    always_comb begin
        rd_a = read_fwd(ra_a, regs[ra_a[AW-1:0]], wa_e, wd_e, wa_m, wd_m);
        rd_b = read_fwd(ra_b, regs[ra_b[AW-1:0]], wa_e, wd_e, wa_m, wd_m);
    end

    // Write-back; the M write is issued last so it wins a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (idx_ok(wa_e))
                regs[wa_e[AW-1:0]] <= wd_e;
            if (idx_ok(wa_m))
                regs[wa_m[AW-1:0]] <= wd_m;
        end
    end

endmodule

// File: rtl/pipe_decode_wb.sv
// Y86-64 PIPE decode + write-back stage: picks source/destination registers
// from icode, reads operands through the bypassing register file and loads
// the D-to-E pipeline register under stall/bubble control.
module pipe_decode_wb
    import y86_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int RIDX_W = 4,
    parameter int NREGS  = 15,
    parameter int RNONE  = y86_pkg::RNONE,
    parameter int RSP    = y86_pkg::RSP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic [RIDX_W-1:0] rA,
    input  logic [RIDX_W-1:0] rB,
    input  logic [RIDX_W-1:0] w_dstE,
    input  logic [WORD_W-1:0] w_valE,
    input  logic [RIDX_W-1:0] w_dstM,
    input  logic [WORD_W-1:0] w_valM,
    input  logic              e_stall,
    input  logic              e_bubble,
    output logic [RIDX_W-1:0] d_srcA,
    output logic [RIDX_W-1:0] d_srcB,
    output logic [3:0]        E_icode,
    output logic [WORD_W-1:0] E_valA,
    output logic [WORD_W-1:0] E_valB,
    output logic [RIDX_W-1:0] E_dstE,
    output logic [RIDX_W-1:0] E_dstM,
    output logic [RIDX_W-1:0] E_srcA,
    output logic [RIDX_W-1:0] E_srcB
);

    localparam logic [RIDX_W-1:0] R_NONE = RIDX_W'(RNONE);
    localparam logic [RIDX_W-1:0] R_SP   = RIDX_W'(RSP);

    logic [RIDX_W-1:0] src_a_p0, src_b_p0, dst_e_p0, dst_m_p0;
    logic [WORD_W-1:0] val_a_p0, val_b_p0;

    logic [3:0]        e_icode_p1;
    logic [WORD_W-1:0] e_val_a_p1, e_val_b_p1;
    logic [RIDX_W-1:0] e_dst_e_p1, e_dst_m_p1, e_src_a_p1, e_src_b_p1;

    // ---- D stage: register selection from icode ----
    // Operand and destination choice; unknown icodes touch no register
    always_comb begin
        src_a_p0 = R_NONE;
        src_b_p0 = R_NONE;
        dst_e_p0 = R_NONE;
        dst_m_p0 = R_NONE;
        case (icode)
            I_RRMOVQ: begin
                src_a_p0 = rA;
                dst_e_p0 = rB;
            end
            I_IRMOVQ: dst_e_p0 = rB;
            I_RMMOVQ: begin
                src_a_p0 = rA;
                src_b_p0 = rB;
            end
            I_MRMOVQ: begin
                src_b_p0 = rB;
                dst_m_p0 = rA;
            end
            I_OPQ: begin
                src_a_p0 = rA;
                src_b_p0 = rB;
                dst_e_p0 = rB;
            end
            I_CALL: begin
                src_b_p0 = R_SP;
                dst_e_p0 = R_SP;
            end
            I_RET: begin
                src_a_p0 = R_SP;
                src_b_p0 = R_SP;
                dst_e_p0 = R_SP;
            end
            I_PUSHQ: begin
                src_a_p0 = rA;
                src_b_p0 = R_SP;
                dst_e_p0 = R_SP;
            end
            I_POPQ: begin
                src_a_p0 = R_SP;
                src_b_p0 = R_SP;
                dst_e_p0 = R_SP;
                dst_m_p0 = rA;
            end
            default: ;
        endcase
    end

    assign d_srcA = src_a_p0;
    assign d_srcB = src_b_p0;

    regfile_2r2w #(
        .WORD_W (WORD_W),
        .RIDX_W (RIDX_W),
        .NREGS  (NREGS),
        .RNONE  (RNONE)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .ra_a (src_a_p0),
        .ra_b (src_b_p0),
        .rd_a (val_a_p0),
        .rd_b (val_b_p0),
        .wa_e (w_dstE),
        .wd_e (w_valE),
        .wa_m (w_dstM),
        .wd_m (w_valM)
    );

    // ---- D -> E boundary ----
    // E register: reset and bubble insert a nop, stall holds everything
    always_ff @(posedge clk) begin
        if (rst || (!e_stall && e_bubble)) begin
            e_icode_p1 <= I_NOP;
            e_val_a_p1 <= '0;
            e_val_b_p1 <= '0;
            e_dst_e_p1 <= R_NONE;
            e_dst_m_p1 <= R_NONE;
            e_src_a_p1 <= R_NONE;
            e_src_b_p1 <= R_NONE;
        end else if (!e_stall) begin
            e_icode_p1 <= icode;
            e_val_a_p1 <= val_a_p0;
            e_val_b_p1 <= val_b_p0;
            e_dst_e_p1 <= dst_e_p0;
            e_dst_m_p1 <= dst_m_p0;
            e_src_a_p1 <= src_a_p0;
            e_src_b_p1 <= src_b_p0;
        end
    end

    assign E_icode = e_icode_p1;
    assign E_valA  = e_val_a_p1;
    assign E_valB  = e_val_b_p1;
    assign E_dstE  = e_dst_e_p1;
    assign E_dstM  = e_dst_m_p1;
    assign E_srcA  = e_src_a_p1;
    assign E_srcB  = e_src_b_p1;

endmodule
